// File: rtl/wb_io_capture_pkg.sv
// wb_io_capture_pkg: register offsets, CTRL/STATUS bit positions
// and field widths shared by the wb_io_capture block.
package wb_io_capture_pkg;

   localparam logic [7:0] OFS_CTRL   = 8'h00;
   localparam logic [7:0] OFS_STATUS = 8'h04;
   localparam logic [7:0] OFS_PINS   = 8'h08;
   localparam logic [7:0] OFS_COUNT  = 8'h0C;
   localparam logic [7:0] OFS_THRESH = 8'h10;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_PSEL_LSB = 2;
   localparam int CTRL_CLEAR    = 7;

   localparam int STAT_PEND = 0;
   localparam int STAT_OVF  = 1;

   localparam int PSEL_W = 5;

endpackage

// File: rtl/io_sync.sv
// io_sync: two-flop synchronizer for asynchronous inputs.
// Ports: clk, rst_n (async, active-low), d (async in), q (synced out).
module io_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/wb_io_capture.sv
// wb_io_capture: Wishbone responder exposing synced io_in, a rising-edge
// counter on a selectable pin, and a threshold interrupt.
// Ports: wb_clk_i, wb_rst_ni (async, active-low), wbs_* classic slave,
// io_in (async pads), irq_o (irq_pend & irq_en).
module wb_io_capture
   import wb_io_capture_pkg::*;
#(
   parameter int          BITS      = 20,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [BITS-1:0] io_in,
   output logic            irq_o
);

   logic [BITS-1:0]   s2;
   logic [BITS-1:0]   s3;
   logic [31:0]       s2_w;
   logic [31:0]       s3_w;

   logic              enable;
   logic              irq_en;
   logic [PSEL_W-1:0] pin_sel;
   logic              irq_pend;
   logic              ovf;
   logic [31:0]       count;
   logic [31:0]       thresh;

   logic              edge_det;
   logic              edge_q;
   logic [31:0]       count_inc;
   logic              set_pend;
   logic              set_ovf;

   logic [7:0]        ofs;
   logic              match;
   logic              req;
   logic              wr;
   logic              hit_ctrl;
   logic              hit_status;
   logic              hit_pins;
   logic              hit_count;
   logic              hit_thresh;
   logic              clear;
   logic              w1c_pend;
   logic              w1c_ovf;
   logic [31:0]       rdata;

   io_sync #(.WIDTH(BITS)) u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .d     (io_in),
      .q     (s2)
   );

   // Zero-extend to 32 bits so any 5-bit pin_sel indexes in range;
   // selects at or above BITS hit constant zeros and never edge.
   assign s2_w = 32'(s2);
   assign s3_w = 32'(s3);

   assign edge_det = enable & s2_w[pin_sel] & ~s3_w[pin_sel];

   assign ofs   = wbs_adr_i[7:0];
   assign match = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req   = wbs_cyc_i & wbs_stb_i & match & ~wbs_ack_o;
   assign wr    = req & wbs_we_i;

   assign hit_ctrl   = (ofs == OFS_CTRL);
   assign hit_status = (ofs == OFS_STATUS);
   assign hit_pins   = (ofs == OFS_PINS);
   assign hit_count  = (ofs == OFS_COUNT);
   assign hit_thresh = (ofs == OFS_THRESH);

   assign clear = wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_CLEAR];

   assign w1c_pend = wr & hit_status & wbs_sel_i[0]
                   & wbs_dat_i[STAT_PEND];
   assign w1c_ovf  = wr & hit_status & wbs_sel_i[0]
                   & wbs_dat_i[STAT_OVF];

   // A clear in the same cycle swallows the edge entirely,
   // including its overflow and threshold side effects.
   assign count_inc = count + 32'd1;
   assign set_pend  = edge_q & ~clear & (count_inc == thresh)
                    & (thresh != 32'd0);
   assign set_ovf   = edge_q & ~clear & (count == '1);

   assign irq_o = irq_pend & irq_en;

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         hit_ctrl: begin
            rdata[CTRL_EN]                        = enable;
            rdata[CTRL_IRQ_EN]                    = irq_en;
            rdata[CTRL_PSEL_LSB +: PSEL_W]        = pin_sel;
         end
         hit_status: begin
            rdata[STAT_PEND] = irq_pend;
            rdata[STAT_OVF]  = ovf;
         end
         hit_pins:   rdata = s2_w;
         hit_count:  rdata = count;
         hit_thresh: rdata = thresh;
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         pin_sel   <= '0;
         irq_pend  <= 1'b0;
         ovf       <= 1'b0;
         count     <= '0;
         thresh    <= '0;
         s3        <= '0;
         edge_q    <= 1'b0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= req ? rdata : '0;
         s3        <= s2;
         edge_q    <= edge_det;

         if (wr && hit_ctrl && wbs_sel_i[0]) begin
            enable  <= wbs_dat_i[CTRL_EN];
            irq_en  <= wbs_dat_i[CTRL_IRQ_EN];
            pin_sel <= wbs_dat_i[CTRL_PSEL_LSB +: PSEL_W];
         end

         for (int b = 0; b < 4; b++) begin
            if (wr && hit_thresh && wbs_sel_i[b])
               thresh[8*b +: 8] <= wbs_dat_i[8*b +: 8];
         end

         irq_pend <= set_pend | (irq_pend & ~w1c_pend);
         ovf      <= set_ovf  | (ovf & ~w1c_ovf);

         if (clear)
            count <= '0;
         else if (edge_q)
            count <= count_inc;
      end
   end

endmodule

// File: doc/wb_io_capture.md
# wb_io_capture

Wishbone responder in the user project area that gives the management SoC visibility of the user IO inputs. It synchronizes `io_in[BITS-1:0]`, counts rising edges on one software-selected pin, and raises an interrupt when the count reaches a programmable threshold. It sits beside the counter that drives `io_out` in `user_project_wrapper`, on the otherwise unused `wbs_*`, `io_in` and `user_irq[0]` connections.

## Interface
- `BITS`, 20: number of `io_in` bits observed.
- `BASE_ADDR`, 32'h3000_0000: block base; decode matches `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i`  in  4  byte enables for writes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o`=1.
- `io_in`  in  BITS  asynchronous pad inputs.
- `irq_o`  out  1  level interrupt, equal to `irq_pend & irq_en`.

## Operation
- Register map, offsets from `adr[7:0]`:
  - 0x00 CTRL, RW: [0] `enable`, [1] `irq_en`, [6:2] `pin_sel`. Bit [7] `clear` is write-1 self-clearing and reads 0.
  - 0x04 STATUS: [0] `irq_pend` W1C, [1] `ovf` sticky W1C.
  - 0x08 PINS, RO: synchronized `io_in`, zero-extended.
  - 0x0C COUNT, RO: 32-bit edge count.
  - 0x10 THRESH, RW: 32-bit threshold.
- RW registers honour `wbs_sel_i` per byte.
- Unmapped offsets, and any write to a RO register:
  - the access is acknowledged;
  - read data is 0;
  - writes have no effect.
- Addresses that do not match the base are not acknowledged.
- Input path: two-flop synchronizer gives `s2`, then one history flop gives `s3`, full width. An edge is `s2[pin_sel] & ~s3[pin_sel]`, qualified by `enable`.
- `pin_sel >= BITS` produces no edges.
- Changing `pin_sel` never produces a spurious edge, because `s2` and `s3` are indexed by the same select.
- Count behaviour:
  - a qualified edge increments COUNT;
  - at 0xFFFF_FFFF it wraps to 0 and sets `ovf`;
  - when the incremented value equals THRESH and THRESH is not 0, `irq_pend` is set. THRESH = 0 never fires.
- Simultaneous events:
  - `clear` and an edge in the same cycle: COUNT becomes 0 and the edge is dropped;
  - a W1C write and a set condition in the same cycle: set wins;
  - a THRESH write and an edge in the same cycle: the compare uses the old THRESH.
- `clear` zeroes COUNT only. It does not touch STATUS.

## Timing
- Reset values: all registers 0, `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0. Synchronizer flops also reset to 0.
- Handshake:
  - `wbs_ack_o` is registered and rises one cycle after `cyc & stb & addr-match & ~ack`;
  - it is high for exactly one cycle;
  - a held strobe gets ack every other cycle, one transfer per ack.
- Read data is registered alongside ack and reflects register state at the request cycle.
- A write takes effect on the same edge that raises ack.
- Pin to count latency: an `io_in` rise sampled at edge N updates COUNT at edge N+3. `irq_o` follows at N+3.
- A new edge is counted only if the pin was low for at least one sample.
- Reset mid-transfer: ack drops immediately and no write completes. The master must restart the cycle.

## Structure
- Package `wb_io_capture_pkg` holds:
  - register offsets (`OFS_CTRL`, `OFS_STATUS`, `OFS_PINS`, `OFS_COUNT`, `OFS_THRESH`);
  - CTRL and STATUS bit positions;
  - the `pin_sel` width (5).
- Sub-module `io_sync`: parameterized-width two-flop synchronizer with async active-low reset. It is instantiated once, at width BITS.
- The Wishbone decode, the register file and the edge counter stay in the top module.

## Test plan
- Reset, then read every offset → all return 0. Each read is acked exactly one cycle after strobe.
- Write CTRL=0x07 (enable, irq_en, pin 1) and THRESH=3, then pulse `io_in[1]` 3 times → COUNT reads 3 and `irq_o` rises 3 cycles after the third rise. Writing STATUS=1 drops `irq_o`.
- Set `pin_sel`=5 and toggle `io_in[1]` → COUNT is unchanged. Set `pin_sel`=25 with `io_in` all ones → no count.
- Write 0xFF to THRESH bytes with `wbs_sel_i`=0010 → THRESH reads 0x0000_FF00. A write to 0x08 reads back unchanged. Address 0x20 is acked with data 0.
- Force COUNT to 0xFFFF_FFFF through edges with a fast-forward backdoor, then one more edge → COUNT=0 and STATUS=0x2.
- Write CTRL with `clear`=1 in the same cycle as a counted edge → COUNT=0.
- Assert `wb_rst_ni`=0 mid-read → ack and data go to 0 asynchronously.
